pcpi_insn_sequencer: RTL and testbench
======================================

PCPI_INSN_SEQUENCER -- requirements
Module: pcpi_insn_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum ISSUE-state cycles with pcpi_wait low before abort; legal range 2..255.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 nib_in  input  4  instruction nibble from pads.
REQ-005 nib_valid  input  1  nib_in holds a valid nibble (level).
REQ-006 nib_ack  output  1  one-cycle pulse, nibble accepted in previous cycle.
REQ-007 pcpi_valid  output  1  coprocessor request.
REQ-008 pcpi_insn  output  32  assembled instruction, stable while pcpi_valid high.
REQ-009 pcpi_ready  input  1  coprocessor completion.
REQ-010 pcpi_wait  input  1  coprocessor is busy; suspends timeout.
REQ-011 pcpi_wr  input  1  pcpi_rd is valid, qualified by pcpi_ready.
REQ-012 pcpi_rd  input  32  coprocessor result.
REQ-013 res_nib  output  4  current result nibble.
REQ-014 res_valid  output  1  res_nib valid.
REQ-015 res_ack  input  1  consumer takes res_nib (counted only while res_valid high).
REQ-016 busy  output  1  high in any state other than LOAD.
REQ-017 done  output  1  one-cycle pulse, transaction complete.
REQ-018 err_timeout  output  1  sticky abort flag.

Function
REQ-019 FSM states: LOAD, ISSUE, DRAIN; 3-bit nibble counter cnt; timeout counter tcnt, 8 bits wide.
REQ-020 LOAD: each cycle with nib_valid=1 writes nib_in into pcpi_insn[4*cnt+3:4*cnt], then increments cnt; nibble 0 is the LSB.
REQ-021 A nibble accepted with cnt=7 sets cnt to 0, clears tcnt and enters ISSUE on the next edge.
REQ-022 nib_valid is ignored in ISSUE and DRAIN, with no nib_ack; partial loads persist across idle cycles.
REQ-023 ISSUE: pcpi_valid=1 combinationally from state; pcpi_insn held constant.
REQ-024 ISSUE with pcpi_wait=0 and pcpi_ready=0: tcnt increments; pcpi_wait=1 holds tcnt.
REQ-025 ISSUE, pcpi_ready=1 and pcpi_wr=1: capture pcpi_rd into the result register, go to DRAIN.
REQ-026 ISSUE, pcpi_ready=1 and pcpi_wr=0: pulse done, go to LOAD.
REQ-027 ISSUE, pcpi_ready=0 and tcnt=TIMEOUT_CYCLES-1 with pcpi_wait=0: set err_timeout, go to LOAD, do not pulse done.
REQ-028 pcpi_ready and timeout in the same cycle: ready wins, no error.
REQ-029 pcpi_valid is low from the first cycle after the ready or abort edge; never high for more than one transaction back-to-back without re-load.
REQ-030 DRAIN: res_valid=1; res_nib = result[4*cnt+3:4*cnt].
REQ-031 DRAIN: res_ack increments cnt; the ack with cnt=7 pulses done, sets cnt to 0, goes to LOAD.
REQ-032 err_timeout clears when the first nibble (cnt=0) of the next instruction is accepted.
REQ-033 done, nib_ack and err_timeout are registered outputs.
REQ-034 pcpi_valid, res_valid and busy decode from state only.

Reset
REQ-035 rst_n=0 at an edge: state=LOAD, cnt=0, tcnt=0, pcpi_insn=0, result=0.
REQ-036 During reset, all outputs are low: nib_ack, pcpi_valid, res_valid, done, err_timeout, busy, res_nib=0.
REQ-037 Reset mid-ISSUE or mid-DRAIN aborts immediately, drops pcpi_valid next cycle, and discards partial data.
REQ-038 Reset has priority over all other events.

Verification
REQ-039 Load 8 nibbles 1,2,...,8 on consecutive cycles; model ready after 3 cycles with wr=1 and rd=0xCAFEF00D -> pcpi_insn=0x87654321 while valid; 8 acks yield D,0,0,F,E,F,A,C, then done pulse.
REQ-040 Load with gaps in nib_valid (nibbles 0xA spaced 3 cycles) -> insn=0xAAAAAAAA; nib_ack is exactly 8 pulses.
REQ-041 TIMEOUT_CYCLES=4, never ready, wait=0 -> pcpi_valid high exactly 4 cycles, err_timeout=1, done=0, busy=0 afterwards.
REQ-042 wait=1 for 20 cycles then ready, wr=0, TIMEOUT_CYCLES=4 -> no error; done pulses; no DRAIN.
REQ-043 Ready coincident with the final timeout cycle -> no err_timeout; result captured.
REQ-044 rst_n low during DRAIN after 3 acks -> all outputs 0 next cycle; fresh 8-nibble load behaves as in REQ-039.

Source files
------------

// File: rtl/pcpi_insn_sequencer.sv
// Nibble-serial front end for a PCPI coprocessor.
// Loads a 32-bit instruction, issues it, then drains the 32-bit result.
module pcpi_insn_sequencer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  nib_in,
  input  logic        nib_valid,
  output logic        nib_ack,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  input  logic        pcpi_ready,
  input  logic        pcpi_wait,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  output logic [3:0]  res_nib,
  output logic        res_valid,
  input  logic        res_ack,
  output logic        busy,
  output logic        done,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [7:0] TLAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic [31:0] insn_q, insn_d;
  logic [31:0] res_q, res_d;
  logic        ack_q, ack_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // Next-state and datapath updates for load, issue and drain phases
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    insn_d  = insn_q;
    res_d   = res_q;
    err_d   = err_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (nib_valid) begin
          insn_d[{cnt_q, 2'b00} +: 4] = nib_in;
          ack_d = 1'b1;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd0) err_d = 1'b0;
          if (cnt_q == 3'd7) begin
            tcnt_d  = 8'd0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (pcpi_ready) begin
          if (pcpi_wr) begin
            res_d   = pcpi_rd;
            state_d = DRAIN;
          end else begin
            done_d  = 1'b1;
            state_d = LOAD;
          end
        end else if (!pcpi_wait) begin
          if (tcnt_q == TLAST) begin
            err_d   = 1'b1;
            state_d = LOAD;
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end
      end
      DRAIN: begin
        if (res_ack) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            done_d  = 1'b1;
            state_d = LOAD;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= 3'd0;
      tcnt_q  <= 8'd0;
      insn_q  <= 32'd0;
      res_q   <= 32'd0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      insn_q  <= insn_d;
      res_q   <= res_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign pcpi_valid  = (state_q == ISSUE);
  assign res_valid   = (state_q == DRAIN);
  assign busy        = (state_q != LOAD);
  assign res_nib     = res_valid ? res_q[{cnt_q, 2'b00} +: 4] : 4'd0;
  assign pcpi_insn   = insn_q;
  assign nib_ack     = ack_q;
  assign done        = done_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_pcpi_insn_sequencer.sv
// Directed plus randomized transactions against a
// transaction-level model of the nibble sequencer.
module tb_pcpi_insn_sequencer;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  nib_in;
  logic        nib_valid;
  logic        nib_ack;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic        pcpi_ready;
  logic        pcpi_wait;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic [3:0]  res_nib;
  logic        res_valid;
  logic        res_ack;
  logic        busy;
  logic        done;
  logic        err_timeout;

  int n_assert = 0;
  int n_fail   = 0;
  bit exp_err  = 1'b0;

  pcpi_insn_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .nib_in      (nib_in),
    .nib_valid   (nib_valid),
    .nib_ack     (nib_ack),
    .pcpi_valid  (pcpi_valid),
    .pcpi_insn   (pcpi_insn),
    .pcpi_ready  (pcpi_ready),
    .pcpi_wait   (pcpi_wait),
    .pcpi_wr     (pcpi_wr),
    .pcpi_rd     (pcpi_rd),
    .res_nib     (res_nib),
    .res_valid   (res_valid),
    .res_ack     (res_ack),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".nib_ack"}, 32'(nib_ack), 32'd0);
    chk({tag, ".pcpi_valid"}, 32'(pcpi_valid), 32'd0);
    chk({tag, ".res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".err"}, 32'(err_timeout), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".res_nib"}, 32'(res_nib), 32'd0);
    chk({tag, ".insn"}, pcpi_insn, 32'd0);
  endtask

  // Feed eight nibbles, LSB first, with gap idle cycles in between
  task automatic load(input logic [31:0] insn, input int gap,
                      output int acks);
    logic [3:0] nibs[8];
    logic [31:0] built;
    built = 32'd0;
    for (int i = 0; i < 8; i++) begin
      nibs[i] = 4'((insn >> (4 * i)) & 32'hF);
      built = built + (32'(nibs[i]) << (4 * i));
    end
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      nib_valid = 1'b1;
      nib_in = nibs[i];
      step();
      acks += int'(nib_ack);
      if (i == 0) begin
        exp_err = 1'b0;
        chk("err_clear_first_nib", 32'(err_timeout), 32'd0);
      end
      if (i < 7) begin
        nib_valid = 1'b0;
        nib_in = 4'($urandom);
        for (int g = 0; g < gap; g++) begin
          step();
          acks += int'(nib_ack);
          chk("load_busy", 32'(busy), 32'd0);
        end
      end
    end
    nib_valid = 1'($urandom);
    nib_in = 4'($urandom);
    chk("issue_valid", 32'(pcpi_valid), 32'd1);
    chk("issue_insn", pcpi_insn, built);
    chk("issue_busy", 32'(busy), 32'd1);
  endtask

  // Coprocessor: n_wait busy cycles, n_idle quiet cycles, then ready
  task automatic issue(input logic [31:0] insn, input int n_wait,
                       input int n_idle, input bit give_ready,
                       input bit wr, input logic [31:0] rd);
    int k;
    bit tmo;
    int exp_cycles;
    tmo = !give_ready || (n_idle >= T);
    exp_cycles = tmo ? (n_wait + T) : (n_wait + n_idle + 1);
    k = 0;
    while (pcpi_valid === 1'b1 && k < 300) begin
      if (pcpi_insn !== insn)
        chk("insn_stable", pcpi_insn, insn);
      pcpi_wait  = (k < n_wait);
      pcpi_ready = give_ready && (k == n_wait + n_idle);
      pcpi_wr    = pcpi_ready ? wr : 1'($urandom);
      pcpi_rd    = pcpi_ready ? rd : $urandom;
      nib_valid  = 1'($urandom);
      step();
      k++;
    end
    pcpi_wait  = 1'b0;
    pcpi_ready = 1'b0;
    nib_valid  = 1'b0;
    if (tmo) exp_err = 1'b1;
    chk("valid_cycles", 32'(k), 32'(exp_cycles));
    chk("err_after_issue", 32'(err_timeout), 32'(exp_err));
    chk("done_after_issue", 32'(done), 32'(!tmo && !wr));
    chk("drain_entered", 32'(res_valid), 32'(!tmo && wr));
    chk("nib_ack_quiet", 32'(nib_ack), 32'd0);
    if (tmo || !wr) begin
      chk("busy_after", 32'(busy), 32'd0);
      step();
      chk("done_one_pulse", 32'(done), 32'd0);
    end
  endtask

  // Consume n result nibbles with random stall cycles
  task automatic drain(input logic [31:0] rd, input int n);
    logic [3:0] nb;
    for (int i = 0; i < n; i++) begin
      nb = 4'((rd >> (4 * i)) & 32'hF);
      if ($urandom_range(0, 2) == 0) begin
        res_ack = 1'b0;
        step();
      end
      chk("drain_valid", 32'(res_valid), 32'd1);
      chk("drain_nib", 32'(res_nib), 32'(nb));
      if (done !== 1'b0) chk("drain_no_done", 32'(done), 32'd0);
      res_ack = 1'b1;
      step();
      res_ack = 1'b0;
    end
    if (n == 8) begin
      chk("drain_done", 32'(done), 32'd1);
      chk("drain_exit", 32'(res_valid), 32'd0);
      chk("drain_idle", 32'(busy), 32'd0);
      step();
      chk("drain_done_pulse", 32'(done), 32'd0);
    end
  endtask

  task automatic txn(input logic [31:0] insn, input int gap,
                     input int n_wait, input int n_idle,
                     input bit give_ready, input bit wr,
                     input logic [31:0] rd);
    int acks;
    load(insn, gap, acks);
    chk("ack_count", 32'(acks), 32'd8);
    issue(insn, n_wait, n_idle, give_ready, wr, rd);
    if (give_ready && wr && n_idle < T) drain(rd, 8);
  endtask

  initial begin
    int acks;
    logic [31:0] ri, rr;
    rst_n = 1'b0;
    nib_in = 4'd0;
    nib_valid = 1'b1;
    pcpi_ready = 1'b0;
    pcpi_wait = 1'b0;
    pcpi_wr = 1'b0;
    pcpi_rd = 32'd0;
    res_ack = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    nib_valid = 1'b0;
    rst_n = 1'b1;
    step();

    txn(32'h8765_4321, 0, 0, 3, 1'b1, 1'b1, 32'hCAFE_F00D);
    txn(32'hAAAA_AAAA, 3, 0, 1, 1'b1, 1'b0, 32'h0);
    txn(32'h1357_9BDF, 0, 0, 0, 1'b0, 1'b0, 32'h0);
    txn(32'h0F0F_1234, 1, 20, 0, 1'b1, 1'b0, 32'h0);
    txn(32'hDEAD_BEEF, 0, 2, T - 1, 1'b1, 1'b1, 32'h0123_4567);

    load(32'h1122_3344, 0, acks);
    issue(32'h1122_3344, 0, 1, 1'b1, 1'b1, 32'h9ABC_DEF0);
    drain(32'h9ABC_DEF0, 3);
    rst_n = 1'b0;
    res_ack = 1'b1;
    step();
    chk_all_zero("mid_drain_rst");
    res_ack = 1'b0;
    rst_n = 1'b1;
    txn(32'h8765_4321, 0, 0, 3, 1'b1, 1'b1, 32'hCAFE_F00D);

    for (int t = 0; t < 12; t++) begin
      ri = $urandom;
      rr = $urandom;
      txn(ri, $urandom_range(0, 2), $urandom_range(0, 5),
          $urandom_range(0, 5), 1'($urandom), 1'($urandom), rr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
